// File: rtl/toggle_pkg.sv
// ----------------------------------------------------------------------------
// toggle_pkg
// Shared types and constants for the toggle input-conditioning path.
//   deb_state_t      : debounce FSM state encoding
//   SYNC_STAGES_MIN  : smallest synchronizer depth that is safe for metastability
// ----------------------------------------------------------------------------
package toggle_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_QUAL_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_QUAL_LO = 2'd3
    } deb_state_t;

    localparam int SYNC_STAGES_MIN = 2;

endpackage : toggle_pkg

// File: rtl/bit_synchronizer.sv
// ----------------------------------------------------------------------------
// bit_synchronizer
// Multi-flop synchronizer for a single asynchronous bit.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, all flops clear to 0
//   d       : asynchronous input
//   q       : synchronized output, STAGES clocks after d
// ----------------------------------------------------------------------------
module bit_synchronizer
    import toggle_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_MIN
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    // Depths below the minimum are silently raised rather than producing an
    // unsafe single-flop synchronizer.
    localparam int N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

    logic [N-1:0] sync_ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[N-2:0], d};
        end
    end

    assign q = sync_ff[N-1];

endmodule : bit_synchronizer

// File: rtl/toggle_pulse_debouncer.sv
// ----------------------------------------------------------------------------
// toggle_pulse_debouncer
// Conditions a raw bouncy input into a single-cycle toggle request for a
// downstream T flip-flop, and counts accepted presses.
//   clk          : clock
//   reset_n      : asynchronous active-low reset
//   btn_in       : raw asynchronous input
//   arm          : when 0, accepted presses emit no pulse and are not counted
//   clr_count    : synchronous clear of press_count (wins over increment)
//   t_pulse      : one-cycle toggle request on press acceptance
//   t_enable     : identical copy of t_pulse for the downstream enable pin
//   stable_level : debounced level of btn_in
//   busy         : a candidate level change is being qualified
//   press_count  : saturating count of emitted pulses
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_LOW     | debounced level 0, waiting for btn_s to rise
// S_QUAL_HI | btn_s high, counting stable cycles toward a press
// S_HIGH    | debounced level 1, waiting for btn_s to fall
// S_QUAL_LO | btn_s low, counting stable cycles toward a release
// ----------------------------------------------------------------------------
module toggle_pulse_debouncer
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_in,
    input  logic               arm,
    input  logic               clr_count,
    output logic               t_pulse,
    output logic               t_enable,
    output logic               stable_level,
    output logic               busy,
    output logic [COUNT_W-1:0] press_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] PC_MAX   = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] PC_ONE   = COUNT_W'(1);

    logic             btn_s;
    deb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_in),
        .q       (btn_s)
    );

    // cnt holds the number of consecutive cycles btn_s has shown the
    // candidate level; it tops out at DEBOUNCE_CYCLES-1 so it never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            S_LOW: begin
                if (btn_s) begin
                    state_nxt = S_QUAL_HI;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_QUAL_HI: begin
                if (!btn_s) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                    accept    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!btn_s) begin
                    state_nxt = S_QUAL_LO;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_QUAL_LO: begin
                if (btn_s) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state register and carry no combinational glitches downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_pulse      <= 1'b0;
            t_enable     <= 1'b0;
            stable_level <= 1'b0;
            busy         <= 1'b0;
        end else begin
            t_pulse      <= accept & arm;
            t_enable     <= accept & arm;
            stable_level <= (state_nxt == S_HIGH) || (state_nxt == S_QUAL_LO);
            busy         <= (state_nxt == S_QUAL_HI) || (state_nxt == S_QUAL_LO);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_count <= '0;
        end else if (clr_count) begin
            press_count <= '0;
        end else if (accept && arm && (press_count != PC_MAX)) begin
            press_count <= press_count + PC_ONE;
        end
    end

endmodule : toggle_pulse_debouncer
